// File: rtl/sadd_pkg.sv
// sadd_pkg: shared types and default sizes for the serial-adder host.
//   sadd_state_e  : host FSM states
//   SADD_OP_W     : default operand width
//   SADD_RES_W    : default result width (operand width + carry)
//   SADD_TIMEOUT  : default wait budget for the first result beat
package sadd_pkg;
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, RESP} sadd_state_e;

  localparam int SADD_OP_W    = 2;
  localparam int SADD_RES_W   = SADD_OP_W + 1;
  localparam int SADD_TIMEOUT = 16;
endpackage

// File: rtl/sadd_shreg.sv
// sadd_shreg: width-W shift register, load has priority over shift.
//   clk, rst : clock, synchronous active-high reset (clears contents)
//   load_i   : parallel load of data_i
//   shift_i  : shift toward MSB, sin_i enters at LSB
//   q_o      : current contents
//   msb_o    : current MSB (serial output)
module sadd_shreg #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o,
  output logic         msb_o
);
  logic [W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i)       sh_d = data_i;
    else if (shift_i) sh_d = {sh_q[W-2:0], sin_i};
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign q_o   = sh_q;
  assign msb_o = sh_q[W-1];
endmodule

// File: rtl/sadd_host.sv
// sadd_host: parallel-to-serial initiator for the serial adder.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/ready/a/b   : operand request port (ready only in IDLE)
//   en_i, ina, inb        : serial operand stream to the adder, MSB first
//   en_o, out             : serial result stream from the adder, MSB first
//   resp_valid/ready      : response handshake, resp_* held until accepted
//   resp_sum              : captured result (left-aligned on a short burst)
//   resp_err              : timeout or short burst
//   resp_mismatch         : resp_sum differs from a+b (0 when resp_err)
module sadd_host import sadd_pkg::*; #(
  parameter int OP_W    = SADD_OP_W,
  parameter int TIMEOUT = SADD_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [OP_W-1:0] req_a,
  input  logic [OP_W-1:0] req_b,
  output logic          en_i,
  output logic          ina,
  output logic          inb,
  input  logic          en_o,
  input  logic          out,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [OP_W:0] resp_sum,
  output logic          resp_err,
  output logic          resp_mismatch
);
  localparam int RES_W = OP_W + 1;
  localparam int BW    = $clog2(RES_W + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  sadd_state_e      state_q, state_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;   // send beats, then receive beats
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [RES_W-1:0] exp_q, exp_d;
  logic             req_ready_q, req_ready_d;
  logic             en_i_q, en_i_d;
  logic             rv_q, rv_d, err_q, err_d, mis_q, mis_d;
  logic [RES_W-1:0] sum_q, sum_d;

  logic             op_ld, op_sh, res_ld, res_sh;
  logic [RES_W-1:0] res_q;
  logic [OP_W-1:0]  a_unused, b_unused;
  logic             res_msb_unused;

  // Operand registers shift in zeros, so ina/inb fall to 0 once drained.
  sadd_shreg #(.W(OP_W)) u_sh_a (
    .clk(clk), .rst(rst), .load_i(op_ld), .data_i(req_a), .shift_i(op_sh),
    .sin_i(1'b0), .q_o(a_unused), .msb_o(ina)
  );
  sadd_shreg #(.W(OP_W)) u_sh_b (
    .clk(clk), .rst(rst), .load_i(op_ld), .data_i(req_b), .shift_i(op_sh),
    .sin_i(1'b0), .q_o(b_unused), .msb_o(inb)
  );
  sadd_shreg #(.W(RES_W)) u_sh_res (
    .clk(clk), .rst(rst), .load_i(res_ld), .data_i('0), .shift_i(res_sh),
    .sin_i(out), .q_o(res_q), .msb_o(res_msb_unused)
  );

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    exp_d   = exp_q;
    en_i_d  = en_i_q;
    rv_d    = rv_q;
    err_d   = err_q;
    mis_d   = mis_q;
    sum_d   = sum_q;
    op_ld   = 1'b0;
    op_sh   = 1'b0;
    res_ld  = 1'b0;
    res_sh  = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        state_d = SEND;
        op_ld   = 1'b1;
        res_ld  = 1'b1;
        exp_d   = RES_W'(req_a) + RES_W'(req_b);
        bcnt_d  = '0;
        en_i_d  = 1'b1;
      end
      SEND: begin
        op_sh = 1'b1;
        if (bcnt_q == BW'(OP_W - 1)) begin
          state_d = WAIT;
          en_i_d  = 1'b0;
          tcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      WAIT: begin
        if (en_o) begin
          res_sh  = 1'b1;
          bcnt_d  = BW'(1);
          state_d = RECV;
        end else if (tcnt_q == TW'(TIMEOUT)) begin
          state_d = RESP;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          mis_d   = 1'b0;
          sum_d   = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      RECV: begin
        // A full burst is checked one cycle after its last beat; en_o is
        // ignored here, so trailing beats never flag an error.
        if (bcnt_q == BW'(RES_W)) begin
          state_d = RESP;
          rv_d    = 1'b1;
          err_d   = 1'b0;
          sum_d   = res_q;
          mis_d   = (res_q != exp_q);
        end else if (en_o) begin
          res_sh = 1'b1;
          bcnt_d = bcnt_q + BW'(1);
        end else begin
          // Short burst: left-align what was captured, zero-pad the tail.
          state_d = RESP;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          mis_d   = 1'b0;
          sum_d   = res_q << (BW'(RES_W) - bcnt_q);
        end
      end
      RESP: if (resp_ready) begin
        rv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      tcnt_q      <= '0;
      exp_q       <= '0;
      req_ready_q <= 1'b0;
      en_i_q      <= 1'b0;
      rv_q        <= 1'b0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      tcnt_q      <= tcnt_d;
      exp_q       <= exp_d;
      req_ready_q <= req_ready_d;
      en_i_q      <= en_i_d;
      rv_q        <= rv_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      sum_q       <= sum_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign en_i          = en_i_q;
  assign resp_valid    = rv_q;
  assign resp_sum      = sum_q;
  assign resp_err      = err_q;
  assign resp_mismatch = mis_q;
endmodule

// File: tb/tb_sadd_host.sv
// tb_sadd_host: directed bench for sadd_host (OP_W=2, TIMEOUT=16).
// The bench plays the adder on en_o/out and checks serial and response
// behaviour against hand-computed values.
module tb_sadd_host;
  localparam int OP_W = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [1:0] req_a, req_b;
  logic       en_i, ina, inb;
  logic       en_o, out;
  logic       resp_valid, resp_ready;
  logic [2:0] resp_sum;
  logic       resp_err, resp_mismatch;

  int n_chk = 0;
  int n_err = 0;

  sadd_host #(.OP_W(OP_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .en_i(en_i), .ina(ina), .inb(inb), .en_o(en_o), .out(out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum),
    .resp_err(resp_err), .resp_mismatch(resp_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a request and check the two operand beats and the en_i fall.
  // Returns just after the edge on which en_i drops.
  task automatic send_req(input string tag, input logic [1:0] a, input logic [1:0] b);
    int n;
    n = 0;
    while (!req_ready && n < 30) begin tick; n++; end
    chk({tag, "_rdy"}, req_ready, 1);
    req_a = a; req_b = b; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    chk({tag, "_b0"}, {en_i, ina, inb}, {1'b1, a[1], b[1]});
    tick;
    chk({tag, "_b1"}, {en_i, ina, inb}, {1'b1, a[0], b[0]});
    tick;
    chk({tag, "_end"}, {en_i, ina, inb}, 3'b000);
  endtask

  // Adder model: n beats of en_o, bits taken MSB first from bits.
  task automatic burst(input int n, input logic [2:0] bits);
    logic [2:0] v;
    v = bits;
    for (int i = 0; i < n; i++) begin
      en_o = 1'b1; out = v[2 - i];
      tick;
    end
    en_o = 1'b0; out = 1'b0;
  endtask

  task automatic wait_resp(input string tag, output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 40) begin tick; cyc++; end
    chk({tag, "_seen"}, resp_valid, 1);
  endtask

  task automatic check_resp(input string tag, input logic [2:0] sum,
                            input logic err, input logic mis);
    chk({tag, "_sum"}, resp_sum, sum);
    chk({tag, "_err"}, resp_err, err);
    chk({tag, "_mis"}, resp_mismatch, mis);
  endtask

  // With resp_ready high, the next edge is the handshake.
  task automatic finish_resp(input string tag);
    tick;
    chk({tag, "_ack"}, {req_ready, resp_valid}, 2'b10);
  endtask

  initial begin
    int cyc;
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    en_o = 1'b0; out = 1'b0; resp_ready = 1'b1;
    tick; tick;
    chk("rst_ready", req_ready, 0);
    chk("rst_ser", {en_i, ina, inb}, 3'b000);
    chk("rst_resp", {resp_valid, resp_sum, resp_err, resp_mismatch}, 6'b0);
    rst = 1'b0;
    tick;
    chk("post_rst_ready", req_ready, 1);

    // 1. Nominal: 3+2 = 5, result beats start two cycles after en_i falls.
    send_req("nom", 2'd3, 2'd2);
    tick;
    burst(3, 3'b101);
    wait_resp("nom", cyc);
    chk("nom_lat", cyc, 1);
    check_resp("nom", 3'd5, 1'b0, 1'b0);
    finish_resp("nom");

    // 2. Mismatch: 1+2 = 3 but adder returns 4.
    send_req("mis", 2'd1, 2'd2);
    tick;
    burst(3, 3'b100);
    wait_resp("mis", cyc);
    check_resp("mis", 3'd4, 1'b0, 1'b1);
    finish_resp("mis");

    // 3. Timeout: no en_o at all.
    send_req("tmo", 2'd1, 2'd1);
    wait_resp("tmo", cyc);
    chk("tmo_lat", cyc, 17);
    check_resp("tmo", 3'd0, 1'b1, 1'b0);
    finish_resp("tmo");

    // 4. Short burst: two beats 1,1 then en_o drops -> 110.
    send_req("shb", 2'd3, 2'd3);
    tick;
    burst(2, 3'b110);
    wait_resp("shb", cyc);
    chk("shb_lat", cyc, 1);
    check_resp("shb", 3'd6, 1'b1, 1'b0);
    finish_resp("shb");

    // 5. Backpressure: 2+1 = 3, hold resp_ready low for 5 cycles.
    resp_ready = 1'b0;
    send_req("bp", 2'd2, 2'd1);
    tick;
    burst(3, 3'b011);
    wait_resp("bp", cyc);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {resp_valid, req_ready, resp_sum, resp_err, resp_mismatch},
          {1'b1, 1'b0, 3'd3, 1'b0, 1'b0});
      tick;
    end
    resp_ready = 1'b1;
    finish_resp("bp");

    // 6. Reset on the second en_i beat drops the request.
    req_a = 2'd3; req_b = 2'd3; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    chk("rst_mid_beat", {en_i, ina, inb}, 3'b111);
    rst = 1'b1;
    tick;
    chk("rst_mid_ser", {en_i, ina, inb}, 3'b000);
    chk("rst_mid_resp", {resp_valid, req_ready}, 2'b00);
    rst = 1'b0;
    tick;
    chk("rst_mid_ready", req_ready, 1);
    burst(3, 3'b110);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) seen = 1;
      tick;
    end
    chk("rst_mid_noresp", seen, 0);

    // Recovery after reset: 0+1 = 1.
    send_req("rec", 2'd0, 2'd1);
    tick;
    burst(3, 3'b001);
    wait_resp("rec", cyc);
    check_resp("rec", 3'd1, 1'b0, 1'b0);
    finish_resp("rec");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
